parser: RTL and testbench

PARSER -- requirements
Module: parser

---
 rtl/parser_pkg.sv | 25 ++
 rtl/seq_tracker.sv | 35 +++
 rtl/parser.sv | 118 +++++++++++
 tb/tb_parser.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/parser_pkg.sv
// Shared constants, header layout and types for the packet parser.
package parser_pkg;

  localparam int OUT_BYTES  = 37;
  localparam int TBL_DEPTH  = 16;
  localparam int BEAT_BYTES = 4;

  // Header byte offsets inside the assembled packet (all fields little-endian)
  localparam int OFF_LEN    = 0;
  localparam int OFF_STREAM = 2;
  localparam int OFF_SEQ    = 4;

  typedef struct packed {
    logic        valid;
    logic [15:0] stream;
    logic [31:0] last_seq;
  } trk_entry_t;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_BODY  = 2'd1,
    ST_PEND  = 2'd2
  } parser_state_e;

endpackage

// File: rtl/seq_tracker.sv
// Per-stream sequence tracking table; flags a gap when a tracked stream skips
// or repeats a sequence number.
module seq_tracker #(
  parameter int TBL_DEPTH = parser_pkg::TBL_DEPTH
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] stream,
  input  logic [31:0] seq,
  input  logic        update,
  output logic        lost
);
  import parser_pkg::*;

  localparam int IDX_W = $clog2(TBL_DEPTH);

  trk_entry_t       tbl [TBL_DEPTH];
  trk_entry_t       cur;
  logic [IDX_W-1:0] idx;

  assign idx = stream[IDX_W-1:0];
  assign cur = tbl[idx];

  // A different stream aliasing onto the same slot is treated as a fresh miss
  assign lost = cur.valid && (cur.stream == stream) && (seq != cur.last_seq + 32'd1);

  always_ff @(posedge clk) begin
    if (reset_b) begin
      for (int i = 0; i < TBL_DEPTH; i++) tbl[i] <= '0;
    end else if (update) begin
      tbl[idx] <= '{valid: 1'b1, stream: stream, last_seq: seq};
    end
  end

endmodule

// File: rtl/parser.sv
// Packet parser: assembles 32-bit beats into a byte buffer, decodes the header
// and reports sequence gaps per stream through a one-deep output register.
module parser #(
  parameter int OUT_BYTES = parser_pkg::OUT_BYTES,
  parameter int TBL_DEPTH = parser_pkg::TBL_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset_b,
  input  logic [31:0]              dataIn,
  input  logic                     dataIn_val,
  output logic                     dataIn_ready,
  input  logic                     dataIN_last,
  output logic [0:8*OUT_BYTES-1]   dataOut,
  output logic                     dataOut_val,
  input  logic                     dataOut_ready,
  output logic                     packetLost,
  output parser_pkg::parser_state_e dbg_state
);
  import parser_pkg::*;

  // Handshakes: a beat moves on a rising edge where dataIn_val && dataIn_ready;
  // a packet leaves on a rising edge where dataOut_val && dataOut_ready.
  parser_state_e state, state_nx;
  logic [3:0]    beat_idx;
  logic [7:0]    asm_buf [OUT_BYTES];
  logic [7:0]    buf_nx  [OUT_BYTES];
  logic          lost_pend;

  logic          acc, first, complete, out_free;
  logic          load_direct, load_pend;
  logic          trk_update, trk_lost, lost_now;
  logic [15:0]   stream_nx;
  logic [31:0]   seq_nx;

  assign dbg_state    = state;
  assign dataIn_ready = (state != ST_PEND) && !reset_b;
  assign acc          = dataIn_val && dataIn_ready;
  assign first        = (state == ST_FIRST);
  assign complete     = acc && dataIN_last;
  assign out_free     = !dataOut_val || dataOut_ready;
  assign load_direct  = complete && out_free;
  assign load_pend    = (state == ST_PEND) && out_free;
  assign trk_update   = complete && !first;
  assign lost_now     = trk_update && trk_lost;

  // Buffer image including the beat being accepted; beat 0 starts from zeros
  always_comb begin
    for (int k = 0; k < OUT_BYTES; k++) begin
      buf_nx[k] = asm_buf[k];
      if (acc && first) buf_nx[k] = 8'h00;
      if (acc && ((k / BEAT_BYTES) == int'(beat_idx)))
        buf_nx[k] = dataIn[8*(BEAT_BYTES-1-(k % BEAT_BYTES)) +: 8];
    end
  end

  // Header decoded from the image, so a one-beat packet naturally reads seq 0
  assign stream_nx = {buf_nx[OFF_STREAM+1], buf_nx[OFF_STREAM]};
  assign seq_nx    = {buf_nx[OFF_SEQ+3], buf_nx[OFF_SEQ+2],
                      buf_nx[OFF_SEQ+1], buf_nx[OFF_SEQ]};

  seq_tracker #(.TBL_DEPTH(TBL_DEPTH)) u_trk (
    .clk     (clk),
    .reset_b (reset_b),
    .stream  (stream_nx),
    .seq     (seq_nx),
    .update  (trk_update),
    .lost    (trk_lost)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_FIRST, ST_BODY: begin
        if (complete)  state_nx = out_free ? ST_FIRST : ST_PEND;
        else if (acc)  state_nx = ST_BODY;
      end
      ST_PEND: if (out_free) state_nx = ST_FIRST;
      default: state_nx = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state     <= ST_FIRST;
      beat_idx  <= 4'd0;
      lost_pend <= 1'b0;
      for (int k = 0; k < OUT_BYTES; k++) asm_buf[k] <= 8'h00;
    end else begin
      state <= state_nx;
      if (acc) begin
        // Saturating count: beats past the buffer end land at offsets that are dropped
        if (dataIN_last)           beat_idx <= 4'd0;
        else if (beat_idx != 4'hF) beat_idx <= beat_idx + 4'd1;
        for (int k = 0; k < OUT_BYTES; k++) asm_buf[k] <= buf_nx[k];
      end
      if (complete) lost_pend <= lost_now;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      dataOut     <= '0;
      dataOut_val <= 1'b0;
      packetLost  <= 1'b0;
    end else if (load_direct) begin
      for (int k = 0; k < OUT_BYTES; k++) dataOut[8*k +: 8] <= buf_nx[k];
      dataOut_val <= 1'b1;
      packetLost  <= lost_now;
    end else if (load_pend) begin
      for (int k = 0; k < OUT_BYTES; k++) dataOut[8*k +: 8] <= asm_buf[k];
      dataOut_val <= 1'b1;
      packetLost  <= lost_pend;
    end else if (dataOut_ready) begin
      dataOut_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parser.sv
// Scoreboard bench for parser: packets are modelled at drive time and the
// expected {packetLost, dataOut} image is compared at each output handshake.
module tb_parser;
  import parser_pkg::*;

  localparam int OB = 37;
  localparam int W  = 8*OB + 1;

  logic              clk = 1'b0;
  logic              reset_b;
  logic [31:0]       dataIn;
  logic              dataIn_val;
  logic              dataIn_ready;
  logic              dataIN_last;
  logic [0:8*OB-1]   dataOut;
  logic              dataOut_val;
  logic              dataOut_ready;
  logic              packetLost;
  parser_state_e     dbg_state;

  logic [W-1:0]      exp_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  bit                rand_rdy = 1'b0;

  logic              m_valid  [16];
  logic [15:0]       m_stream [16];
  logic [31:0]       m_seq    [16];

  always #5 clk = ~clk;

  parser #(.OUT_BYTES(OB), .TBL_DEPTH(16)) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .dataIn        (dataIn),
    .dataIn_val    (dataIn_val),
    .dataIn_ready  (dataIn_ready),
    .dataIN_last   (dataIN_last),
    .dataOut       (dataOut),
    .dataOut_val   (dataOut_val),
    .dataOut_ready (dataOut_ready),
    .packetLost    (packetLost),
    .dbg_state     (dbg_state)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) dataOut_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_stream[i] = 16'h0;
      m_seq[i]    = 32'h0;
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last);
    int t;
    dataIn      = d;
    dataIn_val  = 1'b1;
    dataIN_last = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (dataIn_ready) break;
      t++;
      if (t > 200) begin
        chk("in_timeout", 0, 1);
        dataIn_val = 1'b0;
        return;
      end
      step();
    end
    step();
    dataIn_val  = 1'b0;
    dataIN_last = 1'b0;
  endtask

  task automatic send_pkt(input logic [15:0] stream, input logic [31:0] seq, input int nbeats);
    logic [7:0]      b [48];
    logic [0:8*OB-1] ed;
    logic [15:0]     len;
    logic            l;
    int              ix;
    len = 16'(4 * nbeats);
    for (int k = 0; k < 48; k++) b[k] = 8'($urandom_range(0, 255));
    b[0] = len[7:0];    b[1] = len[15:8];
    b[2] = stream[7:0]; b[3] = stream[15:8];
    b[4] = seq[7:0];    b[5] = seq[15:8];  b[6] = seq[23:16]; b[7] = seq[31:24];
    ed = '0;
    for (int k = 0; k < OB; k++) if (k < 4 * nbeats) ed[8*k +: 8] = b[k];
    l = 1'b0;
    if (nbeats >= 2) begin
      ix = int'(stream[3:0]);
      l  = m_valid[ix] && (m_stream[ix] == stream) && (seq != m_seq[ix] + 32'd1);
      m_valid[ix] = 1'b1; m_stream[ix] = stream; m_seq[ix] = seq;
    end
    exp_q.push_back({l, ed});
    for (int i = 0; i < nbeats; i++) begin
      if (rand_rdy) repeat ($urandom_range(0, 2)) step();
      drive_beat({b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]}, i == nbeats - 1);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      step();
      t++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset_b && dataOut_val && dataOut_ready) begin
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pkt", {packetLost, dataOut}, e);
      end
    end
  end

  initial begin
    int sn [4];
    logic [15:0] sl [4];
    reset_b = 1'b1; dataIn = '0; dataIn_val = 1'b0; dataIN_last = 1'b0; dataOut_ready = 1'b1;
    model_clear();
    sl[0] = 16'd1; sl[1] = 16'd17; sl[2] = 16'd33; sl[3] = 16'd2;
    for (int j = 0; j < 4; j++) sn[j] = $urandom_range(0, 1000);
    repeat (3) step();
    chk("rst_val",   dataOut_val, 0);
    chk("rst_lost",  packetLost, 0);
    chk("rst_data",  {1'b0, dataOut}, 0);
    chk("rst_ready", dataIn_ready, 0);
    reset_b = 1'b0;
    #1;
    chk("ready_after_rst", dataIn_ready, 1);

    // Basic decode, latency and zero fill
    send_pkt(16'd12, 32'd1, 5);
    chk("latency_val", dataOut_val, 1);
    chk("hdr_bytes",   dataOut[0:63], 64'h14000C0001000000);
    chk("tail_zero",   dataOut[160:295], 0);
    chk("lost_first",  packetLost, 0);

    // Gap detection
    send_pkt(16'd13, 32'd1, 6);
    send_pkt(16'd12, 32'd3, 9);
    send_pkt(16'd12, 32'd4, 3);
    // Oversized packet: beats 10-11 dropped
    send_pkt(16'd7, 32'd100, 12);
    // Aliasing stream replaces the entry
    send_pkt(16'd12, 32'd5, 4);
    send_pkt(16'd28, 32'd9, 4);
    send_pkt(16'd12, 32'd6, 4);
    // Single-beat packet must not touch the table
    send_pkt(16'd3, 32'd50, 2);
    send_pkt(16'd3, 32'd99, 1);
    send_pkt(16'd3, 32'd51, 2);
    // Sequence wrap is in order
    send_pkt(16'd5, 32'hFFFF_FFFF, 2);
    send_pkt(16'd5, 32'h0, 2);
    wait_drain();

    // Back-pressure: first packet held, second pends
    dataOut_ready = 1'b0;
    send_pkt(16'd9, 32'd1, 3);
    chk("held_val", dataOut_val, 1);
    send_pkt(16'd9, 32'd2, 4);
    chk("pend_ready", dataIn_ready, 0);
    chk("held_a0", {packetLost, dataOut}, exp_q[0]);
    step();
    step();
    chk("held_a1", {packetLost, dataOut}, exp_q[0]);
    chk("pend_ready2", dataIn_ready, 0);
    dataOut_ready = 1'b1;
    step();
    chk("pend_out_val", dataOut_val, 1);
    chk("pend_out", {packetLost, dataOut}, exp_q[0]);
    chk("ready_free", dataIn_ready, 1);
    wait_drain();

    // Random traffic with random back-pressure and idle gaps
    rand_rdy = 1'b1;
    for (int p = 0; p < 16; p++) begin
      int j;
      logic [31:0] s;
      j = $urandom_range(0, 3);
      s = 32'(sn[j]) + (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
      sn[j] = int'(s) + 1;
      send_pkt(sl[j], s, $urandom_range(1, 12));
    end
    rand_rdy = 1'b0;
    dataOut_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a packet
    drive_beat(32'h1400_0C00, 1'b0);
    drive_beat(32'h0700_0000, 1'b0);
    drive_beat(32'hDEAD_BEEF, 1'b0);
    reset_b = 1'b1;
    step();
    chk("mid_rst_val",   dataOut_val, 0);
    chk("mid_rst_lost",  packetLost, 0);
    chk("mid_rst_data",  {1'b0, dataOut}, 0);
    chk("mid_rst_ready", dataIn_ready, 0);
    step();
    reset_b = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_ready_after", dataIn_ready, 1);
    send_pkt(16'd12, 32'd77, 3);
    chk("post_rst_lost", packetLost, 0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
